// File: rtl/round_timer_pkg.sv
// rtl/round_timer_pkg.sv - shared types and constants for the round countdown timer
package round_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  // Two packed BCD digits; the packed layout keeps numeric ordering so
  // relational compares on the whole struct work directly.
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  localparam logic [7:0] BCD_MAX = 8'h99;

  // True when both nibbles are legal decimal digits.
  function automatic logic is_bcd2(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd2_addsub.sv
// rtl/bcd2_addsub.sv - combinational two-digit BCD add/subtract, saturating at 00 and 99
module bcd2_addsub
  import round_timer_pkg::*;
(
  input  bcd2_t a,
  input  bcd2_t b,
  input  logic  sub,
  output bcd2_t y
);

  logic [4:0] ones_raw;
  logic [4:0] tens_raw;
  logic [3:0] ones_fix;
  logic       carry;

  // Digit-wise binary op, then +6/-6 correction on the ones digit; a tens
  // overflow/underflow clamps the result instead of wrapping.
  always_comb begin
    ones_raw = '0;
    tens_raw = '0;
    ones_fix = '0;
    carry    = 1'b0;
    y        = '0;
    if (sub) begin
      ones_raw = {1'b0, a.ones} - {1'b0, b.ones};
      carry    = ones_raw[4];
      ones_fix = carry ? (ones_raw[3:0] - 4'd6) : ones_raw[3:0];
      tens_raw = {1'b0, a.tens} - {1'b0, b.tens} - {4'd0, carry};
      if (tens_raw[4]) begin
        y = '0;
      end else begin
        y.tens = tens_raw[3:0];
        y.ones = ones_fix;
      end
    end else begin
      ones_raw = {1'b0, a.ones} + {1'b0, b.ones};
      carry    = (ones_raw > 5'd9);
      ones_fix = carry ? (ones_raw[3:0] + 4'd6) : ones_raw[3:0];
      tens_raw = {1'b0, a.tens} + {1'b0, b.tens} + {4'd0, carry};
      if (tens_raw > 5'd9) begin
        y = bcd2_t'(BCD_MAX);
      end else begin
        y.tens = tens_raw[3:0];
        y.ones = ones_fix;
      end
    end
  end

endmodule

// File: rtl/round_timer_ctrl.sv
// rtl/round_timer_ctrl.sv - game-round countdown FSM driving the timebase turbo and BCD seconds display
module round_timer_ctrl
  import round_timer_pkg::*;
#(
  parameter logic [7:0] ROUND_SEC = 8'h60,
  parameter logic [7:0] BONUS_SEC = 8'h05,
  parameter logic [7:0] WARN_SEC  = 8'h10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause_tgl,
  input  logic       bonus,
  input  logic       fast_fwd,
  input  logic       one_sec,
  output logic       turbo,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones,
  output logic       running,
  output logic       expired,
  output logic       expired_pulse,
  output logic       warning
);

  if (!is_bcd2(ROUND_SEC)) begin : g_bad_round
    $error("ROUND_SEC must be two BCD digits");
  end
  if (!is_bcd2(BONUS_SEC) || (BONUS_SEC == 8'h00)) begin : g_bad_bonus
    $error("BONUS_SEC must be two BCD digits and at least 01");
  end
  if (!is_bcd2(WARN_SEC)) begin : g_bad_warn
    $error("WARN_SEC must be two BCD digits");
  end

  state_t state;
  state_t state_n;
  bcd2_t  cnt;
  bcd2_t  cnt_n;
  bcd2_t  op_b;
  bcd2_t  sum;
  bcd2_t  bonus_m1;
  logic   op_sub;
  logic   use_tick;
  logic   pulse_n;
  logic   turbo_n;
  logic   warn_n;

  // Bonus and tick together collapse into a single add of (BONUS_SEC - 1),
  // so saturation at 99 is applied once to the net result.
  bcd2_addsub u_bonus_m1 (
    .a  (bcd2_t'(BONUS_SEC)),
    .b  (bcd2_t'(8'h01)),
    .sub(1'b1),
    .y  (bonus_m1)
  );

  bcd2_addsub u_arith (
    .a  (cnt),
    .b  (op_b),
    .sub(op_sub),
    .y  (sum)
  );

  // Pick the arithmetic operation; ticks only count while RUNNING.
  always_comb begin
    use_tick = (state == RUNNING) && one_sec;
    op_sub   = 1'b0;
    op_b     = bcd2_t'(BONUS_SEC);
    if (use_tick && bonus) begin
      op_b = bonus_m1;
    end else if (use_tick) begin
      op_b   = bcd2_t'(8'h01);
      op_sub = 1'b1;
    end
  end

  // Next state, next count and next registered outputs.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pulse_n = 1'b0;
    if (start) begin
      state_n = RUNNING;
      cnt_n   = bcd2_t'(ROUND_SEC);
    end else begin
      unique case (state)
        IDLE: begin
        end
        RUNNING: begin
          if (one_sec || bonus) begin
            cnt_n = sum;
          end
          if (one_sec && !bonus && (sum == '0)) begin
            state_n = EXPIRED;
            pulse_n = 1'b1;
          end else if (pause_tgl) begin
            state_n = PAUSED;
          end
        end
        PAUSED: begin
          if (bonus) begin
            cnt_n = sum;
          end
          if (pause_tgl) begin
            state_n = RUNNING;
          end
        end
        EXPIRED: begin
          cnt_n = '0;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
    turbo_n = fast_fwd && (state_n == RUNNING);
    warn_n  = (state == RUNNING) && (cnt <= bcd2_t'(WARN_SEC));
  end

  // State and output registers; reset aborts the round at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      turbo         <= 1'b0;
      expired_pulse <= 1'b0;
      warning       <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      turbo         <= turbo_n;
      expired_pulse <= pulse_n;
      warning       <= warn_n;
    end
  end

  assign secs_tens = cnt.tens;
  assign secs_ones = cnt.ones;
  assign running   = (state == RUNNING);
  assign expired   = (state == EXPIRED);

endmodule

// File: tb/tb_round_timer_ctrl.sv
// tb/tb_round_timer_ctrl.sv - scoreboard bench for round_timer_ctrl
module tb_round_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, pause_tgl, bonus, fast_fwd, one_sec;
  logic       turbo, running, expired, expired_pulse, warning;
  logic [3:0] secs_tens, secs_ones;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         due;
    int         ph;
    string      name;
    logic [7:0] dig;
    logic       run;
    logic       expd;
    logic       pulse;
    logic       warn;
    logic       cw;
    logic       turbo;
  } exp_t;

  exp_t q[$];

  round_timer_ctrl dut (
    .clk          (clk),
    .reset        (rst),
    .start        (start),
    .pause_tgl    (pause_tgl),
    .bonus        (bonus),
    .fast_fwd     (fast_fwd),
    .one_sec      (one_sec),
    .turbo        (turbo),
    .secs_tens    (secs_tens),
    .secs_ones    (secs_ones),
    .running      (running),
    .expired      (expired),
    .expired_pulse(expired_pulse),
    .warning      (warning)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  // One clock of stimulus; the expectation is for the outputs after the next edge.
  task automatic step(input string name, input logic s, p, b, t, f,
                      input logic [7:0] d, input logic r, x, xp, w, cw, tu);
    exp_t e;
    @(posedge clk);
    #2;
    start = s; pause_tgl = p; bonus = b; one_sec = t; fast_fwd = f;
    e.due = cyc + 1; e.ph = 0; e.name = name; e.dig = d; e.run = r;
    e.expd = x; e.pulse = xp; e.warn = w; e.cw = cw; e.turbo = tu;
    q.push_back(e);
  endtask

  task automatic ticks(input int from, input int count);
    for (int i = 1; i <= count; i++)
      step("run_tick", 0, 0, 0, 1, 0, bcd(from - i), 1, 0, 0, 0, 0, 0);
  endtask

  // Assert reset between edges and expect every output cleared before the next edge.
  task automatic async_rst();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    e.due = cyc; e.ph = 1; e.name = "async_reset"; e.dig = 8'h00; e.run = 0;
    e.expd = 0; e.pulse = 0; e.warn = 0; e.cw = 1; e.turbo = 0;
    q.push_back(e);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic check_slot(input int ph);
    exp_t e;
    logic [7:0] act;
    logic ok;
    while (q.size() > 0 && (q[0].due < cyc || (q[0].due == cyc && q[0].ph <= ph))) begin
      e = q.pop_front();
      n_cmp++;
      if (e.due != cyc || e.ph != ph) begin
        n_bad++;
        $display("FAIL %s: missed sampling slot, due cycle %0d phase %0d, now cycle %0d phase %0d",
                 e.name, e.due, e.ph, cyc, ph);
      end else begin
        act = {secs_tens, secs_ones};
        ok = (act === e.dig) && (running === e.run) && (expired === e.expd) &&
             (expired_pulse === e.pulse) && (turbo === e.turbo) &&
             (!e.cw || (warning === e.warn));
        if (!ok) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got digits=%h run=%b exp=%b pulse=%b warn=%b turbo=%b, want digits=%h run=%b exp=%b pulse=%b warn=%b(chk %b) turbo=%b",
                   e.name, cyc, act, running, expired, expired_pulse, warning, turbo,
                   e.dig, e.run, e.expd, e.pulse, e.warn, e.cw, e.turbo);
        end
      end
    end
  endtask

  // Monitor: pops and compares whatever is due at each sampling slot.
  initial begin
    forever begin
      @(negedge clk);
      check_slot(0);
      #3;
      check_slot(1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    start = 0; pause_tgl = 0; bonus = 0; fast_fwd = 0; one_sec = 0;
    repeat (3) step("reset", 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0);
    rst = 1'b0;
    step("idle_ignores", 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0);

    // Full 60-second countdown to expiry
    step("start", 1, 0, 0, 0, 0, 8'h60, 1, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 60; k++) begin
      n = 60 - k;
      step("tick", 0, 0, 0, 1, 0, bcd(n), n != 0, n == 0, n == 0, 0, 0, 0);
      repeat (2)
        step("hold", 0, 0, 0, 0, 0, bcd(n), n != 0, n == 0, 0, (n >= 1 && n <= 10), 1, 0);
    end

    // Pause and resume at 42, bonus while paused
    step("start2", 1, 0, 0, 0, 0, 8'h60, 1, 0, 0, 0, 1, 0);
    ticks(60, 18);
    step("pause", 0, 1, 0, 0, 0, 8'h42, 0, 0, 0, 0, 1, 0);
    repeat (5) step("paused_tick", 0, 0, 0, 1, 0, 8'h42, 0, 0, 0, 0, 1, 0);
    step("resume", 0, 1, 0, 0, 0, 8'h42, 1, 0, 0, 0, 1, 0);
    step("tick41", 0, 0, 0, 1, 0, 8'h41, 1, 0, 0, 0, 0, 0);
    step("tick40", 0, 0, 0, 1, 0, 8'h40, 1, 0, 0, 0, 0, 0);
    step("pause2", 0, 1, 0, 0, 0, 8'h40, 0, 0, 0, 0, 1, 0);
    step("paused_bonus", 0, 0, 1, 0, 0, 8'h45, 0, 0, 0, 0, 1, 0);
    step("resume2", 0, 1, 0, 0, 0, 8'h45, 1, 0, 0, 0, 1, 0);

    // Bonus with BCD carry, saturation, and bonus+tick
    step("start3", 1, 0, 0, 0, 0, 8'h60, 1, 0, 0, 0, 1, 0);
    ticks(60, 3);
    for (int k = 1; k <= 8; k++)
      step("bonus", 0, 0, 1, 0, 0, bcd(57 + 5 * k), 1, 0, 0, 0, 1, 0);
    step("bonus_sat", 0, 0, 1, 0, 0, 8'h99, 1, 0, 0, 0, 1, 0);
    ticks(99, 69);
    step("bonus_tick", 0, 0, 1, 1, 0, 8'h34, 1, 0, 0, 0, 1, 0);

    // Pause and final tick together: expiry wins
    ticks(34, 33);
    step("pause_tick_01", 0, 1, 0, 1, 0, 8'h00, 0, 1, 1, 0, 0, 0);
    step("expired_ignores", 0, 1, 1, 1, 0, 8'h00, 0, 1, 0, 0, 1, 0);

    // Turbo follows fast_fwd only while running
    step("ff_expired", 0, 0, 0, 0, 1, 8'h00, 0, 1, 0, 0, 1, 0);
    step("ff_start", 1, 0, 0, 0, 1, 8'h60, 1, 0, 0, 0, 1, 1);
    step("ff_pause", 0, 1, 0, 0, 1, 8'h60, 0, 0, 0, 0, 1, 0);
    step("ff_resume", 0, 1, 0, 0, 1, 8'h60, 1, 0, 0, 0, 1, 1);
    step("ff_release", 0, 0, 0, 0, 0, 8'h60, 1, 0, 0, 0, 1, 0);

    // Asynchronous reset mid-round, then start with a coincident tick
    ticks(60, 35);
    step("hold25", 0, 0, 0, 0, 0, 8'h25, 1, 0, 0, 0, 1, 0);
    async_rst();
    step("start_tick", 1, 0, 0, 1, 0, 8'h60, 1, 0, 0, 0, 1, 0);
    step("hold60", 0, 0, 0, 0, 0, 8'h60, 1, 0, 0, 0, 1, 0);

    repeat (4) @(posedge clk);
    if (q.size() != 0) begin
      $display("FAIL leftover: %0d expectations never compared, want 0", q.size());
      n_bad += q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
